mux4_1_rr: RTL and testbench
============================

# mux4_1_rr

Four-to-one round-robin channel merger: the gathering counterpart of the team's 1:4 demultiplexer. Four producer channels, each with a valid/ready handshake, feed one registered output channel. The output carries a 2-bit source select that uses the same s1/s0 channel encoding as the demux. The block sits upstream of a single consumer, or of the demux itself, to funnel four streams into one shared path without losing or duplicating words.

## Interface
Parameters:
- WIDTH, 8, data word width of every input and of the output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  4  bit i: channel i presents a word.
- in_data  input  4*WIDTH  channel i word in bits [i*WIDTH +: WIDTH].
- in_ready  output  4  bit i: channel i word accepted this cycle (combinational).
- out_valid  output  1  registered output word is valid.
- out_data  output  WIDTH  registered output word.
- out_sel  output  2  registered source channel of out_data ({s1,s0} encoding, 0..3).
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation
- Output stage: one register holding out_valid, out_data and out_sel.
- The load enable is combinational: load = !out_valid || out_ready.
- Round-robin pointer ptr is 2 bits; it names the highest-priority channel.
- Search order: ptr, ptr+1, ptr+2, ptr+3, all mod 4. The grant g goes to the first channel with in_valid set.
- in_ready[g] = load && |in_valid; every other in_ready bit is 0. in_ready never asserts for a channel whose in_valid is 0.
- Transfer: on a clock edge where in_valid[g] && in_ready[g]:
  - out_data <= word of channel g;
  - out_sel <= g;
  - out_valid <= 1;
  - ptr <= g+1 mod 4 (3 wraps to 0).
- Drain without refill: if out_valid && out_ready and no in_valid is set, out_valid <= 0. out_data and out_sel keep their last values.
- Backpressure: while out_valid && !out_ready, all in_ready bits are 0. out_valid, out_data and out_sel hold unchanged, and ptr holds.
- A producer must keep in_valid and in_data stable until it sees in_ready. The block does not check this.
- Every accepted input word appears exactly once on the output, in acceptance order.

## Timing
- Reset values, applied asynchronously while rst_n = 0: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0. in_ready = 0 follows from !|in_valid or from the reset state.
- Reset release is synchronous to clk. The first grant is possible on the first edge after release.
- Latency: a word accepted at edge N gives out_valid = 1 with that word after edge N.
- Throughput: one word per cycle while out_ready = 1 and any channel is valid.
- A simultaneous output consume and input accept on the same edge replaces the word with no bubble.
- Combinational paths:
  - in_ready depends on in_valid, out_ready and state.
  - out_* are register outputs only; there is no combinational path from inputs to out_*.
- Reset mid-transfer: a held word is dropped and out_valid = 0 immediately. No in_ready asserts while rst_n = 0.
- Fairness: with all four channels continuously valid, each channel is granted once in every 4 consecutive grants.

## Test plan
- Reset state: drive rst_n = 0 with in_valid = 4'b1111 -> out_valid = 0, out_data = 0, out_sel = 0, in_ready = 4'b0000. Release rst_n, out_ready = 1 -> channel 0 is granted first (out_sel = 0).
- Single channel: in_valid = 4'b0100, channel 2 data 8'hA5, out_ready = 1 -> in_ready = 4'b0100. Next cycle out_valid = 1, out_data = 8'hA5, out_sel = 2'b10. Then in_valid = 0 -> out_valid drops after the consuming edge.
- Rotation: all four channels valid with data 8'h10, 8'h21, 8'h32, 8'h43, out_ready = 1 for 8 cycles -> out_sel sequence is 0,1,2,3,0,1,2,3 with the matching data, and out_valid is held at 1 throughout.
- Backpressure: out_valid = 1 with out_sel = 1, then out_ready = 0 for 3 cycles -> in_ready = 0 and out_data/out_sel are frozen. Set out_ready = 1 -> the next grant is channel 2.
- Wrap priority: the last grant was channel 3 (ptr = 0), then in_valid = 4'b1001 -> channel 0 is granted. Next grant is channel 3.
- Reset mid-operation: rst_n pulses low for 1 cycle while out_valid = 1 and out_ready = 0 -> out_valid = 0 asynchronously, ptr = 0. After release, in_valid = 4'b0110 -> channel 1 is granted first.

Source files
------------

// File: rtl/mux4_1_rr.sv
// Four-to-one round-robin merger: four valid/ready producers funnel into one
// registered output word tagged with its source channel ({s1,s0} encoding).
module mux4_1_rr #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    input  logic               out_ready
);

    // Handshake: a word moves on a rising edge where valid and ready are both
    // high; producers hold valid/data until ready, the consumer sees a word
    // until it raises out_ready, and ready never depends on the ready of a peer
    // on the same side.

    logic [1:0]       ptr;
    logic [1:0]       grant;
    logic             any_valid;
    logic             load;
    logic [WIDTH-1:0] grant_word;

    assign any_valid = |in_valid;
    assign load      = !out_valid || out_ready;

    // Walk the search order backwards so the channel closest to ptr wins.
    always_comb begin
        grant = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[ptr + 2'(k)]) begin
                grant = ptr + 2'(k);
            end
        end
    end

    assign grant_word = in_data[int'(grant)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = 4'b0000;
        if (rst_n && load && any_valid) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
        end else if (load) begin
            if (any_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_word;
                out_sel   <= grant;
                ptr       <= grant + 2'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux4_1_rr.sv
// Bench for mux4_1_rr: directed scenarios plus randomized traffic against a
// behavioural model of the merger and an in-order word scoreboard.
module tb_mux4_1_rr;

    localparam int WIDTH = 8;
    localparam int W     = WIDTH + 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_ready;

    mux4_1_rr #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       m_sel;
    int               m_ptr;
    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     got_q[$];

    function automatic int model_grant();
        for (int i = 0; i < 4; i++) begin
            if (in_valid[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int g;
        g = model_grant();
        if (rst_n === 1'b1 && (!m_valid || out_ready) && g >= 0) return 4'b0001 << g;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 2'd0;
        m_ptr   = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_word(input int ch, input logic [WIDTH-1:0] w);
        in_data[ch*WIDTH +: WIDTH] = w;
    endtask

    // One clock edge; advances the model and logs consumed/accepted words.
    task automatic tick(output int acc_ch);
        int   g;
        logic acc;
        g      = model_grant();
        acc    = (rst_n === 1'b1) && (!m_valid || out_ready) && (g >= 0);
        acc_ch = acc ? g : -1;
        if (out_valid && out_ready) got_q.push_back({out_sel, out_data});
        @(posedge clk);
        if (acc) begin
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_sel   = 2'(g);
            m_valid = 1'b1;
            m_ptr   = (g + 1) % 4;
            exp_q.push_back({m_sel, m_data});
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int a;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) set_word(c, 8'(8'h50 + c));
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 2'd0, 8'h00}) begin
            errors++;
            $display("FAIL reset_out: got v=%b sel=%0d data=%h want v=0 sel=0 data=00", out_valid, out_sel, out_data);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", in_ready);
        end
        rst_n = 1'b1;
        #1;
        tick(a);
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 8'h50}) begin
            errors++;
            $display("FAIL reset_first_grant: got v=%b sel=%0d data=%h want v=1 sel=0 data=50", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_single();
        int a;
        in_valid = 4'b0100;
        set_word(2, 8'hA5);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b want 0100", in_ready);
        end
        tick(a);
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, 8'hA5}) begin
            errors++;
            $display("FAIL single_out: got v=%b sel=%0d data=%h want v=1 sel=2 data=a5", out_valid, out_sel, out_data);
        end
        in_valid = 4'b0000;
        tick(a);
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 2'd2, 8'hA5}) begin
            errors++;
            $display("FAIL single_drain: got v=%b sel=%0d data=%h want v=0 sel=2 data=a5", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_rotation();
        int               a;
        logic [WIDTH-1:0] words [4];
        words = '{8'h10, 8'h21, 8'h32, 8'h43};
        do_reset();
        for (int c = 0; c < 4; c++) set_word(c, words[c]);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(a);
            checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 2'(k % 4), words[k % 4]}) begin
                errors++;
                $display("FAIL rotation_%0d: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         k, out_valid, out_sel, out_data, k % 4, words[k % 4]);
            end
        end
    endtask

    task automatic test_backpressure();
        int a;
        in_valid = 4'b0010;
        tick(a);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready_%0d: got %b want 0000", k, in_ready);
            end
            tick(a);
            checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 2'd1, 8'h21}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b sel=%0d data=%h want v=1 sel=1 data=21", k, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 0100", in_ready);
        end
        tick(a);
        checks++;
        if (out_sel !== 2'd2) begin
            errors++;
            $display("FAIL bp_release_sel: got %0d want 2", out_sel);
        end
    endtask

    task automatic test_wrap();
        int a;
        in_valid = 4'b1000;
        tick(a);
        in_valid = 4'b1001;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_ready0: got %b want 0001", in_ready);
        end
        tick(a);
        checks++;
        if ({out_valid, out_sel} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL wrap_sel0: got v=%b sel=%0d want v=1 sel=0", out_valid, out_sel);
        end
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_ready3: got %b want 1000", in_ready);
        end
        tick(a);
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd3, 8'h43}) begin
            errors++;
            $display("FAIL wrap_sel3: got v=%b sel=%0d data=%h want v=1 sel=3 data=43", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_reset_mid();
        int a;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        tick(a);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got out_valid=%b want 0", out_valid);
        end
        in_valid  = 4'b0110;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_ready: got %b want 0000", in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_release_ready: got %b want 0010", in_ready);
        end
        tick(a);
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd1, 8'h21}) begin
            errors++;
            $display("FAIL mid_release_sel: got v=%b sel=%0d data=%h want v=1 sel=1 data=21", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_random();
        int   a;
        logic pend [4];
        logic [3:0] exp_rdy;
        do_reset();
        pend      = '{1'b0, 1'b0, 1'b0, 1'b0};
        in_valid  = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    pend[c] = 1'b1;
                    set_word(c, 8'($urandom_range(0, 255)));
                end
                in_valid[c] = pend[c];
            end
            out_ready = (k >= 380) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (k >= 380) in_valid = 4'b0000;
            #1;
            exp_rdy = model_ready();
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready_%0d: got %b want %b", k, in_ready, exp_rdy);
            end
            tick(a);
            if (a >= 0) pend[a] = 1'b0;
            checks++;
            if ({out_valid, out_sel, out_data} !== {m_valid, m_sel, m_data}) begin
                errors++;
                $display("FAIL rand_out_%0d: got v=%b sel=%0d data=%h want v=%b sel=%0d data=%h",
                         k, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sb_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [W-1:0] g;
            logic [W-1:0] e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL sb_word: got sel=%0d data=%h want sel=%0d data=%h", g[W-1:WIDTH], g[WIDTH-1:0], e[W-1:WIDTH], e[WIDTH-1:0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        in_valid  = 4'b0000;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
